// File: rtl/cp0_int_timer.sv
// cp0_int_timer -- coprocessor 0 interrupt and timer unit.
//
// This unit holds the free-running Count register and N_TIMERS Compare
// channels, each with its own pending bit. It also holds Status (IM/EXL/IE),
// the two software interrupt bits of Cause, and synchronisers for the
// external interrupt lines. From this state it produces a prioritised
// interrupt request for the exception unit.
//
// Optional build macro:
//   CP0_COUNT_HALF_RATE_EN  Count advances every second cycle. A toggle
//                           flop gates the increment, and a Count write
//                           clears the toggle.
//
// Ports:
//   CLK, RESET_N   clock, asynchronous active-low reset
//   WE             MTC0 write strobe for register IDX/SEL
//   IDX, SEL       CP0 register number / select (SEL picks compare channel)
//   WD             write data
//   RD             combinational read data for IDX/SEL
//   HW_INT         asynchronous level interrupt lines
//   IEN_WB         writeback holds a real instruction; interrupts are
//                  blocked on bubbles
//   E_ENTER, ERET  exception entry / return this cycle
//   EXL            exception level
//   INT_REQ        interrupt request
//   INT_CODE       highest pending unmasked IP index (7 = highest priority)
module cp0_int_timer #(
  parameter int N_TIMERS    = 2,
  parameter int N_HW_INT    = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                       CLK,
  input  logic                                       RESET_N,
  input  logic                                       WE,
  input  logic [4:0]                                 IDX,
  input  logic [2:0]                                 SEL,
  input  logic [31:0]                                WD,
  output logic [31:0]                                RD,
  input  logic [((N_HW_INT > 0) ? N_HW_INT : 1)-1:0] HW_INT,
  input  logic                                       IEN_WB,
  input  logic                                       E_ENTER,
  input  logic                                       ERET,
  output logic                                       EXL,
  output logic                                       INT_REQ,
  output logic [2:0]                                 INT_CODE
);

  localparam int         HW_W        = (N_HW_INT > 0) ? N_HW_INT : 1;
  localparam logic [4:0] IDX_COUNT   = 5'd9;
  localparam logic [4:0] IDX_COMPARE = 5'd11;
  localparam logic [4:0] IDX_STATUS  = 5'd12;
  localparam logic [4:0] IDX_CAUSE   = 5'd13;
  localparam logic [4:0] IDX_PEND    = 5'd22;

  logic [31:0]         count_q;
  logic [31:0]         cmp_q [N_TIMERS];
  logic [N_TIMERS-1:0] pend_q;
  logic [N_TIMERS-1:0] pend_d;
  logic [7:0]          im_q;
  logic                ie_q;
  logic                exl_q;
  logic [1:0]          sw_ip_q;
  logic [HW_W-1:0]     sync_q [SYNC_STAGES];

  logic                wr_count;
  logic                wr_status;
  logic                wr_cause;
  logic                wr_pend;
  logic [N_TIMERS-1:0] wr_cmp;
  logic                ti;
  logic [7:0]          ip;
  logic [7:0]          masked;
  logic [7:0]          pend8;
  logic [31:0]         cmp_rd;

  assign wr_count  = WE && (IDX == IDX_COUNT);
  assign wr_status = WE && (IDX == IDX_STATUS);
  assign wr_cause  = WE && (IDX == IDX_CAUSE);
  assign wr_pend   = WE && (IDX == IDX_PEND);

  // A compare write with SEL beyond the last channel matches no channel,
  // so the write is dropped.
  always_comb begin
    wr_cmp = '0;
    for (int k = 0; k < N_TIMERS; k++) begin
      wr_cmp[k] = WE && (IDX == IDX_COMPARE) && (SEL == 3'(k));
    end
  end

`ifdef CP0_COUNT_HALF_RATE_EN
  logic tog_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_q <= '0;
      tog_q   <= 1'b0;
    end else if (wr_count) begin
      count_q <= WD;
      tog_q   <= 1'b0;
    end else begin
      tog_q <= ~tog_q;
      if (tog_q) begin
        count_q <= count_q + 32'd1;
      end
    end
  end
`else
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count_q <= '0;
    end else if (wr_count) begin
      count_q <= WD;
    end else begin
      count_q <= count_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < N_TIMERS; k++) begin
        cmp_q[k] <= 32'hFFFF_FFFF;
      end
    end else begin
      for (int k = 0; k < N_TIMERS; k++) begin
        if (wr_cmp[k]) begin
          cmp_q[k] <= WD;
        end
      end
    end
  end

  // Pend priority, weakest first: W1C, then a Count/Compare match, then
  // the clear caused by re-arming the channel through a Compare write.
  always_comb begin
    pend_d = pend_q;
    for (int k = 0; k < N_TIMERS; k++) begin
      if (wr_pend && WD[k]) begin
        pend_d[k] = 1'b0;
      end
      if (count_q == cmp_q[k]) begin
        pend_d[k] = 1'b1;
      end
      if (wr_cmp[k]) begin
        pend_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Exception entry overrides return, and both override a Status write.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      im_q    <= '0;
      ie_q    <= 1'b0;
      exl_q   <= 1'b1;
      sw_ip_q <= '0;
    end else begin
      if (wr_status) begin
        im_q <= WD[15:8];
        ie_q <= WD[0];
      end
      if (E_ENTER) begin
        exl_q <= 1'b1;
      end else if (ERET) begin
        exl_q <= 1'b0;
      end else if (wr_status) begin
        exl_q <= WD[1];
      end
      if (wr_cause) begin
        sw_ip_q <= WD[9:8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= HW_INT;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign ti = |pend_q;

  // The timer shares IP[7] with the top hardware line.
  always_comb begin
    ip = {6'b0, sw_ip_q};
    for (int j = 0; j < N_HW_INT; j++) begin
      ip[2+j] = sync_q[SYNC_STAGES-1][j];
    end
    ip[7] = ip[7] | ti;
  end

  assign masked  = ip & im_q;
  assign INT_REQ = ie_q & ~exl_q & IEN_WB & (|masked);
  assign EXL     = exl_q;

  // Ascending scan, so the highest set index is the last to assign.
  always_comb begin
    INT_CODE = '0;
    for (int b = 0; b < 8; b++) begin
      if (masked[b]) begin
        INT_CODE = 3'(b);
      end
    end
  end

  always_comb begin
    pend8                 = '0;
    pend8[N_TIMERS-1:0]   = pend_q;
  end

  always_comb begin
    cmp_rd = '0;
    for (int k = 0; k < N_TIMERS; k++) begin
      if (SEL == 3'(k)) begin
        cmp_rd = cmp_q[k];
      end
    end
  end

  always_comb begin
    RD = '0;
    case (IDX)
      IDX_COUNT:   RD = count_q;
      IDX_COMPARE: RD = cmp_rd;
      IDX_STATUS:  RD = {16'b0, im_q, 6'b0, exl_q, ie_q};
      IDX_CAUSE:   RD = {1'b0, ti, 14'b0, ip, 8'b0};
      IDX_PEND:    RD = {24'b0, pend8};
      default:     RD = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_int_timer.sv
// Testbench for cp0_int_timer: directed scenarios plus a randomized run,
// all checked against an architectural reference model.
module tb_cp0_int_timer;

  localparam int NT = 2;
  localparam int NH = 6;
  localparam int SS = 2;
`ifdef CP0_COUNT_HALF_RATE_EN
  localparam bit HALF = 1'b1;
  localparam int WRAP = 4;
`else
  localparam bit HALF = 1'b0;
  localparam int WRAP = 2;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        WE = 1'b0;
  logic [4:0]  IDX = '0;
  logic [2:0]  SEL = '0;
  logic [31:0] WD = '0;
  logic [5:0]  HW_INT = '0;
  logic        IEN_WB = 1'b0;
  logic        E_ENTER = 1'b0;
  logic        ERET = 1'b0;
  logic [31:0] RD;
  logic        EXL;
  logic        INT_REQ;
  logic [2:0]  INT_CODE;

  int total = 0;
  int bad = 0;

  cp0_int_timer #(.N_TIMERS(NT), .N_HW_INT(NH), .SYNC_STAGES(SS)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .WE(WE), .IDX(IDX), .SEL(SEL), .WD(WD),
    .RD(RD), .HW_INT(HW_INT), .IEN_WB(IEN_WB), .E_ENTER(E_ENTER),
    .ERET(ERET), .EXL(EXL), .INT_REQ(INT_REQ), .INT_CODE(INT_CODE)
  );

  always #5 CLK = ~CLK;

  // Reference model: architectural register contents.
  logic [31:0] m_count;
  logic [31:0] m_cmp [NT];
  logic [NT-1:0] m_pend;
  logic [7:0]  m_im;
  logic        m_ie;
  logic        m_exl;
  logic [1:0]  m_sw;
  logic        m_tog;
  logic [5:0]  m_hw [$];   // HW_INT samples, newest first

  task automatic model_reset();
    m_count = '0;
    for (int k = 0; k < NT; k++) m_cmp[k] = 32'hFFFF_FFFF;
    m_pend = '0; m_im = '0; m_ie = 1'b0; m_exl = 1'b1; m_sw = '0; m_tog = 1'b0;
    m_hw.delete();
  endtask

  task automatic model_edge();
    logic [NT-1:0] np;
    np = m_pend;
    for (int k = 0; k < NT; k++) begin
      if (WE && IDX == 5'd22 && WD[k]) np[k] = 1'b0;
      if (m_count == m_cmp[k]) np[k] = 1'b1;
      if (WE && IDX == 5'd11 && SEL == k) np[k] = 1'b0;
    end
    for (int k = 0; k < NT; k++)
      if (WE && IDX == 5'd11 && SEL == k) m_cmp[k] = WD;
    if (WE && IDX == 5'd9) begin
      m_count = WD; m_tog = 1'b0;
    end else if (!HALF) begin
      m_count = m_count + 32'd1;
    end else begin
      if (m_tog) m_count = m_count + 32'd1;
      m_tog = ~m_tog;
    end
    if (WE && IDX == 5'd12) begin m_im = WD[15:8]; m_ie = WD[0]; end
    if (E_ENTER) m_exl = 1'b1;
    else if (ERET) m_exl = 1'b0;
    else if (WE && IDX == 5'd12) m_exl = WD[1];
    if (WE && IDX == 5'd13) m_sw = WD[9:8];
    m_hw.push_front(HW_INT);
    if (m_hw.size() > SS) void'(m_hw.pop_back());
    m_pend = np;
  endtask

  function automatic logic [7:0] m_ip();
    logic [5:0] h;
    logic [7:0] ip;
    h = (m_hw.size() >= SS) ? m_hw[SS-1] : 6'd0;
    ip = {h, m_sw};
    ip[7] = ip[7] | (|m_pend);
    return ip;
  endfunction

  function automatic logic m_req();
    return m_ie && !m_exl && IEN_WB && ((m_ip() & m_im) != 8'd0);
  endfunction

  function automatic logic [2:0] m_code();
    logic [7:0] m;
    m = m_ip() & m_im;
    for (int b = 7; b >= 0; b--) if (m[b]) return 3'(b);
    return 3'd0;
  endfunction

  function automatic logic [31:0] m_rd();
    logic [31:0] c;
    case (IDX)
      5'd9:  return m_count;
      5'd11: begin
        c = '0;
        for (int k = 0; k < NT; k++) if (SEL == k) c = m_cmp[k];
        return c;
      end
      5'd12: return {16'b0, m_im, 6'b0, m_exl, m_ie};
      5'd13: return {1'b0, |m_pend, 14'b0, m_ip(), 8'b0};
      5'd22: return {24'b0, 8'(m_pend)};
      default: return 32'd0;
    endcase
  endfunction

  task automatic cyc();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic wr(input logic [4:0] i, input logic [2:0] s, input logic [31:0] d);
    WE = 1'b1; IDX = i; SEL = s; WD = d;
    cyc();
    WE = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    #12;
    total++; if (EXL !== 1'b1) begin bad++; $display("FAIL reset_exl: got %b expected 1", EXL); end
    total++; if (INT_REQ !== 1'b0) begin bad++; $display("FAIL reset_int_req: got %b expected 0", INT_REQ); end
    total++; if (INT_CODE !== 3'd0) begin bad++; $display("FAIL reset_int_code: got %0d expected 0", INT_CODE); end
    IDX = 5'd11; SEL = 3'd1; #1;
    total++; if (RD !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_compare1: got %h expected ffffffff", RD); end
    IDX = 5'd12; #1;
    total++; if (RD !== 32'h0000_0002) begin bad++; $display("FAIL reset_status: got %h expected 00000002", RD); end
    @(negedge CLK);
    RESET_N = 1'b1;
    model_reset();
  endtask

  task automatic test_timer();
    int guard;
    IEN_WB = 1'b1;
    wr(5'd11, 3'd0, 32'd10);
    wr(5'd12, 3'd0, 32'h8001);
    guard = 0;
    while (m_count != 32'd10 && guard < 40) begin cyc(); guard++; end
    IDX = 5'd9; #1;
    total++; if (RD !== 32'd10) begin bad++; $display("FAIL timer_count: got %0d expected 10", RD); end
    total++; if (INT_REQ !== 1'b0) begin bad++; $display("FAIL timer_early_req: got %b expected 0", INT_REQ); end
    cyc(); #1;
    total++; if (INT_REQ !== 1'b1) begin bad++; $display("FAIL timer_req: got %b expected 1", INT_REQ); end
    total++; if (INT_CODE !== 3'd7) begin bad++; $display("FAIL timer_code: got %0d expected 7", INT_CODE); end
    wr(5'd11, 3'd0, 32'd1000); #1;
    total++; if (INT_REQ !== 1'b0) begin bad++; $display("FAIL timer_rearm_req: got %b expected 0", INT_REQ); end
  endtask

  task automatic test_pend();
    int guard;
    wr(5'd9, 3'd0, 32'd0);
    wr(5'd11, 3'd1, 32'd5);
    wr(5'd11, 3'd0, 32'd7);
    guard = 0;
    while (m_count != 32'd6 && guard < 40) begin cyc(); guard++; end
    IDX = 5'd22; #1;
    total++; if (RD !== 32'h02) begin bad++; $display("FAIL pend_after5: got %h expected 02", RD); end
    guard = 0;
    while (m_count != 32'd8 && guard < 40) begin cyc(); guard++; end
    IDX = 5'd22; #1;
    total++; if (RD !== 32'h03) begin bad++; $display("FAIL pend_after7: got %h expected 03", RD); end
    wr(5'd22, 3'd0, 32'h01);
    IDX = 5'd22; #1;
    total++; if (RD !== 32'h02) begin bad++; $display("FAIL pend_w1c: got %h expected 02", RD); end
    IDX = 5'd13; #1;
    total++; if (RD[30] !== 1'b1) begin bad++; $display("FAIL pend_ti: got %b expected 1", RD[30]); end
    total++; if (INT_REQ !== 1'b1) begin bad++; $display("FAIL pend_req: got %b expected 1", INT_REQ); end
  endtask

  task automatic test_hw();
    wr(5'd12, 3'd0, 32'h0401);
    HW_INT = 6'b000001;
    for (int i = 1; i <= SS; i++) begin
      cyc();
      HW_INT = 6'b0;
      IDX = 5'd13; #1;
      total++;
      if (RD[10] !== (i == SS)) begin
        bad++; $display("FAIL hw_sync_stage%0d: got %b expected %b", i, RD[10], (i == SS));
      end
    end
    total++; if (INT_CODE !== 3'd2) begin bad++; $display("FAIL hw_code: got %0d expected 2", INT_CODE); end
    total++; if (INT_REQ !== 1'b1) begin bad++; $display("FAIL hw_req: got %b expected 1", INT_REQ); end
    IEN_WB = 1'b0; #1;
    total++; if (INT_REQ !== 1'b0) begin bad++; $display("FAIL hw_bubble: got %b expected 0", INT_REQ); end
    IEN_WB = 1'b1;
  endtask

  task automatic test_sw();
    wr(5'd12, 3'd0, 32'h0301);
    wr(5'd13, 3'd0, 32'h300);
    #1;
    total++; if (INT_CODE !== 3'd1) begin bad++; $display("FAIL sw_code: got %0d expected 1", INT_CODE); end
    total++; if (INT_REQ !== 1'b1) begin bad++; $display("FAIL sw_req: got %b expected 1", INT_REQ); end
    E_ENTER = 1'b1; ERET = 1'b1;
    cyc();
    E_ENTER = 1'b0; ERET = 1'b0; #1;
    total++; if (EXL !== 1'b1) begin bad++; $display("FAIL enter_eret_exl: got %b expected 1", EXL); end
    total++; if (INT_REQ !== 1'b0) begin bad++; $display("FAIL enter_eret_req: got %b expected 0", INT_REQ); end
  endtask

  task automatic test_wrap();
    wr(5'd11, 3'd0, 32'd0);
    wr(5'd9, 3'd0, 32'hFFFF_FFFE);
    for (int i = 1; i <= WRAP + 1; i++) begin
      cyc();
      if (i == WRAP - 1) begin
        IDX = 5'd9; #1;
        total++; if (RD !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_pre: got %h expected ffffffff", RD); end
      end
      if (i == WRAP) begin
        IDX = 5'd9; #1;
        total++; if (RD !== 32'd0) begin bad++; $display("FAIL wrap_zero: got %h expected 0", RD); end
        IDX = 5'd22; #1;
        total++; if (RD[0] !== 1'b0) begin bad++; $display("FAIL wrap_pend_early: got %b expected 0", RD[0]); end
      end
      if (i == WRAP + 1) begin
        IDX = 5'd22; #1;
        total++; if (RD[0] !== 1'b1) begin bad++; $display("FAIL wrap_pend: got %b expected 1", RD[0]); end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      WE = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 5))
        0: IDX = 5'd9;
        1: IDX = 5'd11;
        2: IDX = 5'd12;
        3: IDX = 5'd13;
        4: IDX = 5'd22;
        default: IDX = 5'($urandom_range(0, 31));
      endcase
      SEL = 3'($urandom_range(0, 3));
      WD = $urandom;
      if (IDX == 5'd11) WD = m_count + 32'($urandom_range(0, 8));
      HW_INT = 6'($urandom);
      IEN_WB = ($urandom_range(0, 3) != 0);
      E_ENTER = ($urandom_range(0, 15) == 0);
      ERET = ($urandom_range(0, 7) == 0);
      #1;
      total++; if (RD !== m_rd()) begin bad++; $display("FAIL rand_rd[%0d] idx=%0d: got %h expected %h", n, IDX, RD, m_rd()); end
      total++; if (INT_REQ !== m_req()) begin bad++; $display("FAIL rand_req[%0d]: got %b expected %b", n, INT_REQ, m_req()); end
      total++; if (INT_CODE !== m_code()) begin bad++; $display("FAIL rand_code[%0d]: got %0d expected %0d", n, INT_CODE, m_code()); end
      total++; if (EXL !== m_exl) begin bad++; $display("FAIL rand_exl[%0d]: got %b expected %b", n, EXL, m_exl); end
      cyc();
    end
    WE = 1'b0; HW_INT = '0; E_ENTER = 1'b0; ERET = 1'b0; IEN_WB = 1'b1;
  endtask

  task automatic test_reset_mid();
    wr(5'd12, 3'd0, 32'h8001);
    wr(5'd11, 3'd0, m_count + 32'd3);
    for (int i = 0; i < 10; i++) cyc();
    IDX = 5'd22; #1;
    total++; if (RD[0] !== 1'b1) begin bad++; $display("FAIL mid_pend_before: got %b expected 1", RD[0]); end
    total++; if (INT_REQ !== 1'b1) begin bad++; $display("FAIL mid_req_before: got %b expected 1", INT_REQ); end
    #2;
    RESET_N = 1'b0;
    #1;
    total++; if (INT_REQ !== 1'b0) begin bad++; $display("FAIL mid_req: got %b expected 0", INT_REQ); end
    total++; if (INT_CODE !== 3'd0) begin bad++; $display("FAIL mid_code: got %0d expected 0", INT_CODE); end
    total++; if (EXL !== 1'b1) begin bad++; $display("FAIL mid_exl: got %b expected 1", EXL); end
    total++; if (RD !== 32'd0) begin bad++; $display("FAIL mid_pend: got %h expected 0", RD); end
    IDX = 5'd9; #1;
    total++; if (RD !== 32'd0) begin bad++; $display("FAIL mid_count: got %h expected 0", RD); end
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_timer();
    test_pend();
    test_hw();
    test_sw();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
